// File: rtl/key_cmd_pkg.sv
// Shared key codes, repeat-FSM state type and command payload for the key command scheduler.
package key_cmd_pkg;

    localparam int unsigned KEY_W = 2;
    localparam int unsigned NKEYS = 4;

    localparam logic [KEY_W-1:0] KEY_UP    = 2'b00;
    localparam logic [KEY_W-1:0] KEY_LEFT  = 2'b01;
    localparam logic [KEY_W-1:0] KEY_RIGHT = 2'b10;
    localparam logic [KEY_W-1:0] KEY_ENTER = 2'b11;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_e;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] code;
    } cmd_t;

    function automatic logic [NKEYS-1:0] key_onehot(input logic [KEY_W-1:0] code);
        key_onehot = NKEYS'(1) << code;
    endfunction

    // Fixed grant priority: enter > up > left > right.
    function automatic logic [KEY_W-1:0] pick_key(input logic [NKEYS-1:0] mask);
        if (mask[KEY_ENTER]) begin
            pick_key = KEY_ENTER;
        end else if (mask[KEY_UP]) begin
            pick_key = KEY_UP;
        end else if (mask[KEY_LEFT]) begin
            pick_key = KEY_LEFT;
        end else begin
            pick_key = KEY_RIGHT;
        end
    endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Free-running repeat timer with synchronous clear and terminal-count tick (tick while count == limit).
// Only present when KEY_REPEAT_EN is defined; the scheduler instantiates it in that build only.
`ifdef KEY_REPEAT_EN
module key_repeat_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == limit);

endmodule
`endif

// File: rtl/key_cmd_scheduler.sv
// Turns decoded key make/break events into a prioritized, back-pressured command stream.
// Define KEY_REPEAT_EN to build the left/right auto-repeat FSM and its timer.
module key_cmd_scheduler
    import key_cmd_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES  = 15000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    input  logic             key_release,
    output logic             cmd_valid,
    output logic [KEY_W-1:0] cmd_code,
    input  logic             cmd_ready
);

    logic [NKEYS-1:0] held_q, held_d;
    logic [NKEYS-1:0] pend_q, pend_d;
    cmd_t             cmd_q, cmd_d;

    logic             make_c, brk_c, new_make_c, slot_free_c;
    logic [NKEYS-1:0] key_oh_c, set_c, rep_set_c, pend_all_c, grant_c;

    assign make_c     = key_valid & ~key_release;
    assign brk_c      = key_valid & key_release;
    assign key_oh_c   = key_onehot(key_code);
    // A make for a key already held is keyboard typematic and is ignored.
    assign new_make_c = make_c & ~|(held_q & key_oh_c);

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LIM  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYCLES - 1);

    rep_state_e       state_q, state_d;
    logic [KEY_W-1:0] rep_key_q, rep_key_d;
    logic             tmr_clr_c, tick_c, is_dir_c;
    logic [CNT_W-1:0] limit_c;

    assign is_dir_c = (key_code == KEY_LEFT) || (key_code == KEY_RIGHT);
    assign limit_c  = (state_q == REP_DELAY) ? DELAY_LIM : REPEAT_LIM;

    key_repeat_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst),
        .clear (tmr_clr_c),
        .limit (limit_c),
        .tick  (tick_c)
    );

    // Release of the repeating key beats a same-cycle tick, so no stray repeat escapes.
    always_comb begin
        state_d   = state_q;
        rep_key_d = rep_key_q;
        tmr_clr_c = 1'b0;
        rep_set_c = '0;
        unique case (state_q)
            REP_IDLE: begin
                tmr_clr_c = 1'b1;
                if (new_make_c && is_dir_c) begin
                    state_d   = REP_DELAY;
                    rep_key_d = key_code;
                end
            end
            REP_DELAY, REP_REPEAT: begin
                if (brk_c && (key_code == rep_key_q)) begin
                    state_d   = REP_IDLE;
                    tmr_clr_c = 1'b1;
                end else if (new_make_c && is_dir_c && (key_code != rep_key_q)) begin
                    state_d   = REP_DELAY;
                    rep_key_d = key_code;
                    tmr_clr_c = 1'b1;
                end else if (tick_c) begin
                    state_d   = REP_REPEAT;
                    rep_set_c = key_onehot(rep_key_q);
                    tmr_clr_c = 1'b1;
                end
            end
            default: begin
                state_d   = REP_IDLE;
                tmr_clr_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= REP_IDLE;
            rep_key_q <= KEY_UP;
        end else begin
            state_q   <= state_d;
            rep_key_q <= rep_key_d;
        end
    end
`else
    assign rep_set_c = '0;
`endif

    assign set_c       = (new_make_c ? key_oh_c : '0) | rep_set_c;
    assign pend_all_c  = pend_q | set_c;
    assign slot_free_c = ~cmd_q.valid | cmd_ready;

    // New requests bypass the pending register so a make reaches the output next cycle.
    always_comb begin
        held_d  = held_q;
        cmd_d   = cmd_q;
        grant_c = '0;
        if (make_c) begin
            held_d = held_d | key_oh_c;
        end
        if (brk_c) begin
            held_d = held_d & ~key_oh_c;
        end
        if (slot_free_c) begin
            if (|pend_all_c) begin
                cmd_d.valid = 1'b1;
                cmd_d.code  = pick_key(pend_all_c);
                grant_c     = key_onehot(cmd_d.code);
            end else begin
                cmd_d.valid = 1'b0;
            end
        end
        // A set landing on a bit that was already pending survives its own grant.
        pend_d = (pend_all_c & ~grant_c) | (set_c & pend_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q <= '0;
            pend_q <= '0;
            cmd_q  <= '0;
        end else begin
            held_q <= held_d;
            pend_q <= pend_d;
            cmd_q  <= cmd_d;
        end
    end

    assign cmd_valid = cmd_q.valid;
    assign cmd_code  = cmd_q.code;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler: a per-cycle vector table plus hand-written repeat/reset sequences.
module tb_key_cmd_scheduler;
    import key_cmd_pkg::*;

    localparam int unsigned DLY = 10;
    localparam int unsigned RPT = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned NV  = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid, key_release, cmd_ready, cmd_valid;
    logic [1:0] key_code, cmd_code;

    always #5 clk = ~clk;

    key_cmd_scheduler #(
        .DELAY_CYCLES  (DLY),
        .REPEAT_CYCLES (RPT),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_ready   (cmd_ready)
    );

    typedef struct {
        logic       kv;
        logic [1:0] kc;
        logic       kr;
        logic       rdy;
        logic       ev;
        logic [1:0] ec;
    } vec_t;

    vec_t       tbl [NV];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc;
    int         log_cyc [$];
    logic [1:0] log_code [$];
    int         exp_cyc [$];
    logic [1:0] exp_code [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, sample and log outputs mid-cycle, advance past the next edge.
    task automatic step(input logic kv, input logic [1:0] kc, input logic kr, input logic rdy);
        key_valid   = kv;
        key_code    = kc;
        key_release = kr;
        cmd_ready   = rdy;
        @(negedge clk);
        if (cmd_valid === 1'b1) begin
            log_cyc.push_back(cyc);
            log_code.push_back(cmd_code);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, KEY_UP, 1'b0, rdy);
    endtask

    task automatic seq_begin();
        cyc = 0;
        log_cyc.delete();
        log_code.delete();
        exp_cyc.delete();
        exp_code.delete();
    endtask

    task automatic expect_cmd(input int c, input logic [1:0] code);
        exp_cyc.push_back(c);
        exp_code.push_back(code);
    endtask

    task automatic seq_check(input string name);
        check({name, ".count"}, 32'(log_cyc.size()), 32'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < log_cyc.size(); i++) begin
            check($sformatf("%s.cyc[%0d]", name, i), 32'(log_cyc[i]), 32'(exp_cyc[i]));
            check($sformatf("%s.code[%0d]", name, i), 32'(log_code[i]), 32'(exp_code[i]));
        end
    endtask

    // Left pressed at cycle 0 and released at cycle brk; repeats only in the repeat build.
    task automatic hold_left(input string name, input int brk);
        seq_begin();
        step(1'b1, KEY_LEFT, 1'b0, 1'b1);
        idle(brk - 1, 1'b1);
        step(1'b1, KEY_LEFT, 1'b1, 1'b1);
        idle(12, 1'b1);
        expect_cmd(1, KEY_LEFT);
`ifdef KEY_REPEAT_EN
        for (int t = int'(DLY) + 1; t - 1 < brk; t += int'(RPT)) expect_cmd(t, KEY_LEFT);
`endif
        seq_check(name);
    endtask

    initial begin
        // Burst of right/up/enter under 5 stalled cycles, then a stalled left.
        tbl[0]  = '{1'b1, KEY_RIGHT, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[1]  = '{1'b1, KEY_UP,    1'b0, 1'b0, 1'b1, KEY_RIGHT};
        tbl[2]  = '{1'b1, KEY_ENTER, 1'b0, 1'b0, 1'b1, KEY_RIGHT};
        tbl[3]  = '{1'b1, KEY_RIGHT, 1'b1, 1'b0, 1'b1, KEY_RIGHT};
        tbl[4]  = '{1'b1, KEY_UP,    1'b1, 1'b0, 1'b1, KEY_RIGHT};
        tbl[5]  = '{1'b1, KEY_ENTER, 1'b1, 1'b1, 1'b1, KEY_RIGHT};
        tbl[6]  = '{1'b0, KEY_UP,    1'b0, 1'b1, 1'b1, KEY_ENTER};
        tbl[7]  = '{1'b0, KEY_UP,    1'b0, 1'b1, 1'b1, KEY_UP};
        tbl[8]  = '{1'b0, KEY_UP,    1'b0, 1'b1, 1'b0, 2'b00};
        tbl[9]  = '{1'b1, KEY_LEFT,  1'b0, 1'b0, 1'b0, 2'b00};
        tbl[10] = '{1'b1, KEY_LEFT,  1'b1, 1'b0, 1'b1, KEY_LEFT};
        tbl[11] = '{1'b0, KEY_UP,    1'b0, 1'b0, 1'b1, KEY_LEFT};
        tbl[12] = '{1'b0, KEY_UP,    1'b0, 1'b1, 1'b1, KEY_LEFT};
        tbl[13] = '{1'b0, KEY_UP,    1'b0, 1'b1, 1'b0, 2'b00};

        rst         = 1'b0;
        key_valid   = 1'b0;
        key_code    = KEY_UP;
        key_release = 1'b0;
        cmd_ready   = 1'b1;
        #12;
        check("reset.valid", 32'(cmd_valid), 32'd0);
        check("reset.code", 32'(cmd_code), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(3, 1'b1);

        for (int i = 0; i < int'(NV); i++) begin
            key_valid   = tbl[i].kv;
            key_code    = tbl[i].kc;
            key_release = tbl[i].kr;
            cmd_ready   = tbl[i].rdy;
            @(negedge clk);
            if (tbl[i].ev)
                check($sformatf("tbl[%0d]", i), {29'd0, cmd_valid, cmd_code}, {29'd0, 1'b1, tbl[i].ec});
            else
                check($sformatf("tbl[%0d].valid", i), 32'(cmd_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        idle(4, 1'b1);

        hold_left("left_30", 30);
        hold_left("left_40", 40);

        // Typematic makes of an already-held key yield nothing extra.
        seq_begin();
        step(1'b1, KEY_ENTER, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, KEY_ENTER, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, KEY_ENTER, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, KEY_ENTER, 1'b1, 1'b1);
        idle(6, 1'b1);
        expect_cmd(1, KEY_ENTER);
        seq_check("typematic");

        // Left held, right pressed at 5: right takes over, left never repeats.
        seq_begin();
        step(1'b1, KEY_LEFT, 1'b0, 1'b1);
        idle(4, 1'b1);
        step(1'b1, KEY_RIGHT, 1'b0, 1'b1);
        idle(12, 1'b1);
        step(1'b1, KEY_RIGHT, 1'b1, 1'b1);
        step(1'b1, KEY_LEFT, 1'b1, 1'b1);
        idle(12, 1'b1);
        expect_cmd(1, KEY_LEFT);
        expect_cmd(6, KEY_RIGHT);
`ifdef KEY_REPEAT_EN
        expect_cmd(16, KEY_RIGHT);
`endif
        seq_check("retarget");

        // Reset mid-handshake while left is held with a stalled command.
        seq_begin();
        step(1'b1, KEY_LEFT, 1'b0, 1'b1);
        idle(11, 1'b0);
        check("pre_reset", {30'd0, cmd_valid, cmd_code[0]}, {30'd0, 1'b1, 1'b1});
        #2;
        rst = 1'b0;
        #1;
        check("reset_async.valid", 32'(cmd_valid), 32'd0);
        check("reset_async.code", 32'(cmd_code), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        seq_begin();
        idle(30, 1'b1);
        seq_check("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
